// File: rtl/fp_pkg.sv
// Shared field layout and FSM encoding for the 8-bit float codec.
// The encoder side reuses the same field-slice constants.
package fp_pkg;

    localparam int E_W = 3;
    localparam int F_W = 4;
    localparam int D_W = 12;

    localparam int S_BIT = 7;
    localparam int E_MSB = 6;
    localparam int E_LSB = 4;
    localparam int F_MSB = 3;
    localparam int F_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_sign_apply.sv
// Combinational conditional negate: res = neg ? -mag : mag (two's complement).
// Zero stays zero when negated, so negative zero needs no special case.
module fp_sign_apply #(
    parameter int W = 12
) (
    input  logic         neg,
    input  logic [W-1:0] mag,
    output logic [W-1:0] res
);

    always_comb begin
        res = mag;
        if (neg) begin
            res = ~mag + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fp_to_lin_decoder.sv
// Float {S,E,F} -> D_W-bit two's-complement, serial shift; out_valid E+2 cycles after accept.
// Stalls in HOLD until out_ready, accepts only in IDLE. FP_DEC_MIDPOINT_EN: midpoint reconstruction.
module fp_to_lin_decoder #(
    parameter int E_W = 3,
    parameter int F_W = 4,
    parameter int D_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [E_W+F_W:0]     fp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_W-1:0]       D,
    output logic                 busy
);

    import fp_pkg::*;

    state_t          state_q, state_d;
    logic            s_q, s_d;
    logic [E_W-1:0]  e_q, e_d;
    logic [E_W-1:0]  cnt_q, cnt_d;
    logic [D_W-1:0]  mag_q, mag_d;
    logic [D_W-1:0]  d_q, d_d;
    logic            out_valid_q, out_valid_d;

    logic [D_W-1:0]  mid_bit;
    logic [D_W-1:0]  mag_final;
    logic [D_W-1:0]  signed_val;

`ifdef FP_DEC_MIDPOINT_EN
    // Centre of the truncation interval: half an LSB of the scaled significand.
    always_comb begin
        mid_bit = '0;
        if (e_q != '0) begin
            mid_bit = {{(D_W-1){1'b0}}, 1'b1} << (e_q - {{(E_W-1){1'b0}}, 1'b1});
        end
    end
`else
    assign mid_bit = '0;
`endif

    assign mag_final = mag_q | mid_bit;

    fp_sign_apply #(.W(D_W)) u_sign_apply (
        .neg (s_q),
        .mag (mag_final),
        .res (signed_val)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = fp_in[S_BIT];
                    e_d     = fp_in[E_MSB:E_LSB];
                    cnt_d   = fp_in[E_MSB:E_LSB];
                    mag_d   = {{(D_W-F_W){1'b0}}, fp_in[F_MSB:F_LSB]};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - {{(E_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                d_d         = signed_val;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            e_q         <= '0;
            cnt_q       <= '0;
            mag_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign D         = d_q;

endmodule

// File: tb/tb_fp_to_lin_decoder.sv
// Directed bench for fp_to_lin_decoder: arithmetic reference model plus literal vectors.
module tb_fp_to_lin_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] dout;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_d;

    fp_to_lin_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_in     (fp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Value = F * 2^E (plus half a step in the midpoint build), then signed.
    function automatic logic [11:0] model(input logic [7:0] fp);
        int e;
        int f;
        int v;
        e = int'(fp[6:4]);
        f = int'(fp[3:0]);
        v = f * (1 << e);
`ifdef FP_DEC_MIDPOINT_EN
        if (e > 0) v = v + (1 << (e - 1));
`endif
        if (fp[7]) v = -v;
        return v[11:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_vs_busy", in_ready, !busy);
            if (out_valid) check("stream_D", dout, exp_d);
        end
    end

    task automatic accept(input logic [7:0] fp);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 50);
        if (!in_ready) check("accept_timeout", 0, 1);
        exp_d    = model(fp);
        in_valid = 1'b1;
        fp_in    = fp;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [11:0] lit, input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        check("D", dout, lit);
    endtask

    task automatic run(input logic [7:0] fp, input logic [11:0] lit, input int lat);
        check("model_pin", model(fp), lit);
        accept(fp);
        wait_out(lit, lat);
    endtask

    logic [7:0]  v_fp  [8];
    logic [11:0] v_d   [8];
    int          v_lat [8];

    initial begin
        v_fp  = '{8'h5D, 8'h2C, 8'hDD, 8'h80, 8'h05, 8'h7F, 8'hFF, 8'h90};
`ifdef FP_DEC_MIDPOINT_EN
        v_d   = '{12'h1B0, 12'h032, 12'hE50, 12'h000, 12'h005, 12'h7C0, 12'h840, 12'hFFF};
`else
        v_d   = '{12'h1A0, 12'h030, 12'hE60, 12'h000, 12'h005, 12'h780, 12'h880, 12'h000};
`endif
        v_lat = '{7, 4, 7, 2, 2, 9, 9, 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fp_in     = 8'h00;
        exp_d     = 12'h000;

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_D", dout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run(v_fp[i], v_d[i], v_lat[i]);
            @(posedge clk);
            #1;
            check("handoff_out_valid", out_valid, 0);
            check("handoff_in_ready", in_ready, 1);
        end

        // Backpressure: HOLD must keep D stable and refuse new input.
        out_ready = 1'b0;
        run(8'h2C, v_d[1], 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                in_valid = 1'b1;
                fp_in    = 8'h7F;
            end
            if (i == 5) in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1);
            check("bp_D", dout, v_d[1]);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);

        // Asynchronous reset while shifting 0x7F.
        accept(8'h7F);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_D", dout, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run(8'h2C, v_d[1], 4);
        @(posedge clk);
        #1;
        check("post_rst_idle", in_ready, 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
